// File: rtl/sap_prog_loader.sv
// SAP-1 program loader: streams DEPTH bytes into RAM from addr 0 and holds the CPU in clear until done.
// Latency: byte accepted at edge M is written during the following cycle; peak rate 1 byte / 2 cycles.
// Backpressure: in_ready is a registered grant; optional trailing checksum under SAP_LOADER_CHECKSUM_EN.
module sap_prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              bus_grant_cpu,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done,
    output logic              prog_valid,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
`ifdef SAP_LOADER_CHECKSUM_EN
        S_CHECK  = 3'd3,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                ram_we_q, ram_we_d;
    logic                in_ready_q, in_ready_d;
    logic                grant_q, grant_d;
    logic                cpu_clr_q, cpu_clr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pvalid_q, pvalid_d;
    logic                fail_d;
`ifdef SAP_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                err_q, err_d;
`endif

    logic xfer;
    logic abort;
    logic last_byte;

    assign xfer      = in_valid && in_ready_q;
    assign abort     = load_abort && (state_q != S_IDLE);
    assign last_byte = (cnt_q + CNT_W'(1)) == CNT_W'(DEPTH);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            in_ready_q <= 1'b0;
            grant_q    <= 1'b1;
            cpu_clr_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pvalid_q   <= 1'b0;
`ifdef SAP_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            in_ready_q <= in_ready_d;
            grant_q    <= grant_d;
            cpu_clr_q  <= cpu_clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pvalid_q   <= pvalid_d;
`ifdef SAP_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (load_start) state_d = S_ACCEPT;
            S_ACCEPT: if (xfer) state_d = S_WRITE;
            S_WRITE: begin
                if (last_byte) begin
`ifdef SAP_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_ACCEPT;
                end
            end
`ifdef SAP_LOADER_CHECKSUM_EN
            S_CHECK:  if (xfer) state_d = S_DONE;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Output registers are loaded from the next state so every flag lines up with the state it describes.
    always_comb begin
        cnt_d      = cnt_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        grant_d    = grant_q;
        cpu_clr_d  = cpu_clr_q;
        pvalid_d   = pvalid_q;
`ifdef SAP_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif

        if (state_q == S_IDLE && load_start) begin
            cnt_d     = '0;
            pvalid_d  = 1'b0;
            grant_d   = 1'b0;
            cpu_clr_d = 1'b1;
`ifdef SAP_LOADER_CHECKSUM_EN
            sum_d     = '0;
            err_d     = 1'b0;
`endif
        end

        if (state_q == S_ACCEPT && xfer && !abort) begin
            ram_data_d = in_data;
            ram_addr_d = cnt_q[ADDR_W-1:0];
`ifdef SAP_LOADER_CHECKSUM_EN
            sum_d      = sum_q + in_data;
`endif
        end

        if (state_q == S_WRITE && !abort) cnt_d = cnt_q + CNT_W'(1);

`ifdef SAP_LOADER_CHECKSUM_EN
        if (state_q == S_CHECK && xfer && !abort) err_d = (in_data != sum_q);
        fail_d = err_d;
`else
        fail_d = 1'b0;
`endif

        if (state_d == S_DONE && state_q != S_DONE) begin
            grant_d   = 1'b1;
            pvalid_d  = !fail_d;
            cpu_clr_d = fail_d;
        end

        if (abort) grant_d = 1'b1;

        in_ready_d = (state_d == S_ACCEPT)
`ifdef SAP_LOADER_CHECKSUM_EN
                     || (state_d == S_CHECK)
`endif
                     ;
        ram_we_d   = (state_d == S_WRITE);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    assign in_ready      = in_ready_q;
    assign ram_addr      = ram_addr_q;
    assign ram_data      = ram_data_q;
    // An abort arriving during the write cycle must keep the strobe off before the RAM samples it.
    assign ram_we        = ram_we_q & ~load_abort;
    assign bus_grant_cpu = grant_q;
    assign cpu_clr       = cpu_clr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign prog_valid    = pvalid_q;
`ifdef SAP_LOADER_CHECKSUM_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_sap_prog_loader.sv
// Directed bench for sap_prog_loader: full loads, back-pressure, abort, async reset and checksum.
module tb_sap_prog_loader;

    logic       clk = 1'b0;
    logic       clr;
    logic       load_start, load_abort, in_valid;
    logic [7:0] in_data;
    logic       in_ready, ram_we, bus_grant_cpu, cpu_clr, busy, done, prog_valid, err;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;

    int total = 0;
    int bad   = 0;
    int both_hi = 0;
    logic [3:0] wa[$];
    logic [7:0] wd[$];
    logic [7:0] pat[16];
    logic [7:0] cks;

    sap_prog_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .clr(clr), .load_start(load_start), .load_abort(load_abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .bus_grant_cpu(bus_grant_cpu), .cpu_clr(cpu_clr), .busy(busy),
        .done(done), .prog_valid(prog_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Write log sampled mid-low-phase, well before the edge at which the RAM captures it.
    always begin
        @(negedge clk);
        #3;
        if (ram_we) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_data);
            if (in_ready) both_hi++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_grant"}, 32'(bus_grant_cpu), 32'd1);
        check({tag, "_cpu_clr"}, 32'(cpu_clr), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_prog_valid"}, 32'(prog_valid), 32'd0);
    endtask

    task automatic send(input logic [7:0] d, input bit gaps);
        int  n;
        bit  acc;
        n = 0;
        acc = 0;
        while (!acc && n < 50) begin
            in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = d;
            acc = in_valid && in_ready;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_load();
        wa.delete();
        wd.delete();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_cpu_clr", 32'(cpu_clr), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_grant", 32'(bus_grant_cpu), 32'd0);
        check("start_prog_valid", 32'(prog_valid), 32'd0);
    endtask

    task automatic run_load(input bit gaps, input bit exp_err);
        int n;
        int exp_lat;
        start_load();
        for (int i = 0; i < 16; i++) send(pat[i], gaps);
`ifdef SAP_LOADER_CHECKSUM_EN
        send(cks, gaps);
        exp_lat = 0;
`else
        check("last_write_we", 32'(ram_we), 32'd1);
        check("last_write_done", 32'(done), 32'd0);
        exp_lat = 1;
`endif
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_latency", 32'(n), 32'(exp_lat));
        check("done_pulse", 32'(done), 32'd1);
        check("done_prog_valid", 32'(prog_valid), 32'(!exp_err));
        check("done_cpu_clr", 32'(cpu_clr), 32'(exp_err));
        check("done_grant", 32'(bus_grant_cpu), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_err", 32'(err), 32'(exp_err));
        @(negedge clk);
        check("after_done", 32'(done), 32'd0);
        check("after_busy", 32'(busy), 32'd0);
        check("after_prog_valid", 32'(prog_valid), 32'(!exp_err));
        check("write_count", 32'(wa.size()), 32'd16);
        for (int i = 0; i < 16 && i < wa.size(); i++) begin
            check("write_addr", 32'(wa[i]), 32'(i));
            check("write_data", 32'(wd[i]), 32'(pat[i]));
        end
    endtask

    task automatic set_pattern(input logic [7:0] base, input logic [7:0] step);
        cks = 8'h00;
        for (int i = 0; i < 16; i++) begin
            pat[i] = base + 8'(i) * step;
            cks = cks + pat[i];
        end
    endtask

    initial begin
        clr = 1'b1;
        load_start = 1'b0;
        load_abort = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        #1;
        check_idle_outputs("reset");
        check("reset_ram_addr", 32'(ram_addr), 32'd0);
        check("reset_ram_data", 32'(ram_data), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Full load with in_valid held high: 0x0E, 0x1F, 0x30, ...
        set_pattern(8'h0E, 8'h11);
        run_load(1'b0, 1'b0);

        // Random back-pressure
        set_pattern(8'hA5, 8'h07);
        run_load(1'b1, 1'b0);
        check("ready_during_write", 32'(both_hi), 32'd0);

        // Abort during the write cycle of byte 5, with a stray start mid-load
        set_pattern(8'h40, 8'h01);
        start_load();
        for (int i = 0; i < 3; i++) send(pat[i], 1'b0);
        load_start = 1'b1;
        send(pat[3], 1'b0);
        load_start = 1'b0;
        for (int i = 4; i < 6; i++) send(pat[i], 1'b0);
        load_abort = 1'b1;
        #1;
        check("abort_we_gated", 32'(ram_we), 32'd0);
        @(negedge clk);
        load_abort = 1'b0;
        check_idle_outputs("abort");
        check("abort_write_count", 32'(wa.size()), 32'd5);
        for (int i = 0; i < 5 && i < wa.size(); i++) begin
            check("abort_addr", 32'(wa[i]), 32'(i));
            check("abort_data", 32'(wd[i]), 32'(pat[i]));
        end
        @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // Start and abort together in IDLE: start wins; then abort from ACCEPT
        load_start = 1'b1;
        load_abort = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        load_abort = 1'b0;
        check("start_wins_busy", 32'(busy), 32'd1);
        check("start_wins_ready", 32'(in_ready), 32'd1);
        load_abort = 1'b1;
        @(negedge clk);
        load_abort = 1'b0;
        check_idle_outputs("accept_abort");

        // Restart after abort begins at address 0
        set_pattern(8'h3C, 8'h05);
        run_load(1'b0, 1'b0);

        // Asynchronous reset after byte 8
        start_load();
        for (int i = 0; i < 8; i++) send(pat[i], 1'b0);
        #2;
        clr = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        check("async_rst_ram_addr", 32'(ram_addr), 32'd0);
        check("async_rst_ram_data", 32'(ram_data), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        set_pattern(8'h77, 8'h13);
        run_load(1'b1, 1'b0);

        // Sixteen 0x11 bytes: checksum 0x10 good, 0x11 bad
        set_pattern(8'h11, 8'h00);
        check("model_cks", 32'(cks), 32'h10);
        run_load(1'b0, 1'b0);
`ifdef SAP_LOADER_CHECKSUM_EN
        cks = 8'h11;
        run_load(1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
